// File: rtl/order_function_register.sv
// Serial capture of the order function field (f13..f17) with complementary rails
// and one-hot decoder-group strobes selected by {f17,f16} for one decode minor cycle.
module order_function_register #(
  parameter int WORD_DIGITS = 18,
  parameter int FUNC_LSB    = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic digit_pulse,
  input  logic minor_cycle_start,
  input  logic order_serial,
  input  logic load_order,
  input  logic decode_enable,
  output logic f13_pos,
  output logic f14_pos,
  output logic f15_pos,
  output logic f16_pos,
  output logic f17_pos,
  output logic f13_neg,
  output logic f14_neg,
  output logic f15_neg,
  output logic f16_neg,
  output logic f17_neg,
  output logic o_dy_0,
  output logic o_dy_1,
  output logic o_dy_2,
  output logic o_dy_3,
  output logic busy,
  output logic sync_err
);

  localparam int CW = $clog2(WORD_DIGITS);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(WORD_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DECODE} state_t;

  state_t        state;
  logic [CW-1:0] digit_cnt;
  logic [4:0]    shift_reg;
  logic [4:0]    shift_next;
  logic [4:0]    func_reg;
  logic [3:0]    dy_reg;
  logic          load_pend;
  logic          decode_pend;
  logic          sync_err_reg;

  logic          start_pulse;
  logic          overrun;
  logic [CW-1:0] digit_idx;
  logic          load_req;
  logic          decode_req;

  assign start_pulse = digit_pulse & minor_cycle_start;
  // A pulse past the last digit without a start means we lost minor-cycle framing.
  assign overrun     = digit_pulse & ~minor_cycle_start & (digit_cnt == LAST_DIGIT);
  assign digit_idx   = minor_cycle_start ? '0 :
                       (digit_cnt == LAST_DIGIT) ? LAST_DIGIT : digit_cnt + CW'(1);
  assign load_req    = load_pend | load_order;
  assign decode_req  = decode_pend | decode_enable;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_shift_bit
      assign shift_next[gi] = (digit_pulse && !overrun && digit_idx == CW'(FUNC_LSB + gi))
                              ? order_serial : shift_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      digit_cnt    <= '0;
      shift_reg    <= '0;
      func_reg     <= '0;
      dy_reg       <= '0;
      load_pend    <= 1'b0;
      decode_pend  <= 1'b0;
      sync_err_reg <= 1'b0;
    end else begin
      load_pend   <= load_req;
      decode_pend <= decode_req;
      if (digit_pulse) digit_cnt <= digit_idx;
      if (overrun) sync_err_reg <= 1'b1;

      case (state)
        IDLE: begin
          if (start_pulse && load_req) begin
            state     <= SHIFT;
            load_pend <= 1'b0;
          end
        end
        SHIFT: begin
          if (overrun) begin
            state <= IDLE;
          end else if (digit_pulse) begin
            shift_reg <= shift_next;
            // Held function updates only here so the rails never show a partial word.
            if (digit_idx == LAST_DIGIT) begin
              func_reg <= shift_next;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (start_pulse) begin
            if (decode_req) begin
              state       <= DECODE;
              decode_pend <= 1'b0;
              dy_reg      <= 4'b0001 << func_reg[4:3];
            end else if (load_req) begin
              state     <= SHIFT;
              load_pend <= 1'b0;
            end
          end
        end
        DECODE: begin
          if (start_pulse) begin
            state  <= HOLD;
            dy_reg <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {f17_pos, f16_pos, f15_pos, f14_pos, f13_pos} = func_reg;
  assign {f17_neg, f16_neg, f15_neg, f14_neg, f13_neg} = ~func_reg;
  assign {o_dy_3, o_dy_2, o_dy_1, o_dy_0}              = dy_reg;
  assign busy     = (state == SHIFT) || (state == DECODE);
  assign sync_err = sync_err_reg;

endmodule

// File: tb/tb_order_function_register.sv
// Directed bench for order_function_register: capture, decode strobes, sync error, async reset.
module tb_order_function_register;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic digit_pulse = 1'b0;
  logic minor_cycle_start = 1'b0;
  logic order_serial = 1'b0;
  logic load_order = 1'b0;
  logic decode_enable = 1'b0;
  logic f13_pos, f14_pos, f15_pos, f16_pos, f17_pos;
  logic f13_neg, f14_neg, f15_neg, f16_neg, f17_neg;
  logic o_dy_0, o_dy_1, o_dy_2, o_dy_3;
  logic busy, sync_err;

  logic [4:0] fpos, fneg;
  logic [3:0] dy;
  assign fpos = {f17_pos, f16_pos, f15_pos, f14_pos, f13_pos};
  assign fneg = {f17_neg, f16_neg, f15_neg, f14_neg, f13_neg};
  assign dy   = {o_dy_3, o_dy_2, o_dy_1, o_dy_0};

  int checks = 0;
  int errors = 0;

  order_function_register dut (
    .clk(clk), .rst_n(rst_n), .digit_pulse(digit_pulse),
    .minor_cycle_start(minor_cycle_start), .order_serial(order_serial),
    .load_order(load_order), .decode_enable(decode_enable),
    .f13_pos(f13_pos), .f14_pos(f14_pos), .f15_pos(f15_pos), .f16_pos(f16_pos), .f17_pos(f17_pos),
    .f13_neg(f13_neg), .f14_neg(f14_neg), .f15_neg(f15_neg), .f16_neg(f16_neg), .f17_neg(f17_neg),
    .o_dy_0(o_dy_0), .o_dy_1(o_dy_1), .o_dy_2(o_dy_2), .o_dy_3(o_dy_3),
    .busy(busy), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic digit(input logic st, input logic b);
    @(negedge clk);
    digit_pulse = 1'b1; minor_cycle_start = st; order_serial = b;
    @(negedge clk);
    digit_pulse = 1'b0; minor_cycle_start = 1'b0; order_serial = 1'b0;
  endtask

  task automatic pulse_load();
    @(negedge clk); load_order = 1'b1;
    @(negedge clk); load_order = 1'b0;
  endtask

  task automatic pulse_decode();
    @(negedge clk); decode_enable = 1'b1;
    @(negedge clk); decode_enable = 1'b0;
  endtask

  function automatic logic [17:0] make_word(input logic [4:0] f);
    logic [17:0] w;
    w = 18'h2AAAA;
    w[16:12] = f;
    return w;
  endfunction

  task automatic minor(input logic [17:0] w);
    for (int d = 0; d < 18; d++) digit(d == 0, w[d]);
  endtask

  initial begin
    logic [17:0] w;
    int cnt;

    // Reset and idle release
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pos", fpos, 5'b00000);
    check("reset_neg", fneg, 5'b11111);
    check("reset_dy", dy, 4'b0000);
    check("reset_busy", busy, 1'b0);
    check("reset_sync_err", sync_err, 1'b0);

    // Load f13..f17 = 0,1,1,0,1
    pulse_load();
    w = make_word(5'b10110);
    for (int d = 0; d < 17; d++) digit(d == 0, w[d]);
    check("shift_busy", busy, 1'b1);
    check("rails_before_d17", fpos, 5'b00000);
    digit(1'b0, w[17]);
    check("load1_pos", fpos, 5'b10110);
    check("load1_neg", fneg, 5'b01001);
    check("load1_busy", busy, 1'b0);

    // Decode: group 2 for exactly one minor cycle
    pulse_decode();
    cnt = 0;
    for (int d = 0; d < 18; d++) begin
      digit(d == 0, 1'b0);
      if (dy == 4'b0100) cnt++;
    end
    check("decode_dy2_digits", cnt, 18);
    digit(1'b1, 1'b0);
    check("decode_end_dy", dy, 4'b0000);
    check("decode_end_busy", busy, 1'b0);
    for (int d = 1; d < 18; d++) digit(1'b0, 1'b0);

    // Decode requested mid-shift of 11111 uses the new function
    pulse_load();
    w = make_word(5'b11111);
    for (int d = 0; d < 18; d++) begin
      digit(d == 0, w[d]);
      if (d == 5) pulse_decode();
    end
    check("load2_pos", fpos, 5'b11111);
    digit(1'b1, 1'b0);
    check("decode2_dy", dy, 4'b1000);
    for (int d = 1; d < 18; d++) digit(1'b0, 1'b0);
    digit(1'b1, 1'b0);
    check("decode2_end_dy", dy, 4'b0000);
    for (int d = 1; d < 18; d++) digit(1'b0, 1'b0);
    check("no_sync_err_yet", sync_err, 1'b0);

    // Withheld start pulse: sync error, function retained
    pulse_load();
    repeat (20) digit(1'b0, 1'b1);
    check("sync_err_set", sync_err, 1'b1);
    check("sync_pos_kept", fpos, 5'b11111);
    check("sync_busy", busy, 1'b0);

    // Resync services the pending load; then reset mid-decode
    minor(make_word(5'b00001));
    check("load3_pos", fpos, 5'b00001);
    check("sync_err_sticky", sync_err, 1'b1);
    pulse_decode();
    pulse_load();
    digit(1'b1, 1'b0);
    check("decode3_dy", dy, 4'b0001);
    repeat (3) digit(1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dy", dy, 4'b0000);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_pos", fpos, 5'b00000);
    check("async_rst_neg", fneg, 5'b11111);
    check("async_rst_sync_err", sync_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    digit(1'b1, 1'b0);
    check("post_rst_no_load", busy, 1'b0);
    for (int d = 1; d < 18; d++) digit(1'b0, 1'b1);
    minor(make_word(5'b11111));
    check("post_rst_pos", fpos, 5'b00000);
    check("post_rst_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
